// File: rtl/io_irq_ctrl.sv
// Vectored interrupt controller: synchronised edge capture, PENDING/MASK/INSERV
// registers, lowest-index priority. Optional ACKCNT counter under IRQ_ACK_COUNT_EN.
module io_irq_ctrl #(
  parameter int          BITS     = 32,
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] BASE     = 32'hF0000100,
  parameter logic [31:0] VEC_BASE = 32'h00000040
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic               intAck,
  output logic               intReq,
  output logic [BITS-1:0]    intVec,
  output logic [BITS-1:0]    dataBusOut
);

  // state   | meaning
  // IDLE    | no request presented
  // REQ     | intReq high, intVec holds latched source's handler
  // SERVICE | handler running, waiting for EOI write to INSERV
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

  localparam logic [BITS-1:0] ADDR_PEND = BITS'(BASE);
  localparam logic [BITS-1:0] ADDR_MASK = BITS'(BASE + 32'd4);
  localparam logic [BITS-1:0] ADDR_SERV = BITS'(BASE + 32'd8);

  stateT              state;
  logic [NUM_SRC-1:0] sync1, sync2, syncQ;
  logic [NUM_SRC-1:0] pending, mask, rise, eligible, w1cClr, ackClr, curSel;
  logic [3:0]         winIdx, curIdx, svcIdx;
  logic               winValid, svcValid, curEnabled, ackTake;
  logic               wrPend, wrMask, eoi, rdPend, rdMask, rdServ;
  logic               unusedBits;

  assign wrPend = we && (memAddr == ADDR_PEND);
  assign wrMask = we && (memAddr == ADDR_MASK);
  assign eoi    = we && (memAddr == ADDR_SERV);
  assign rdPend = re && !we && (memAddr == ADDR_PEND);
  assign rdMask = re && !we && (memAddr == ADDR_MASK);
  assign rdServ = re && !we && (memAddr == ADDR_SERV);

  assign unusedBits = ^dataBusIn[BITS-1:NUM_SRC];

  assign rise     = sync2 & ~syncQ;
  assign eligible = pending & mask;
  assign w1cClr   = wrPend ? dataBusIn[NUM_SRC-1:0] : '0;

  always_comb begin
    winIdx   = '0;
    winValid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winIdx   = 4'(i);
        winValid = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) curSel[i] = (curIdx == 4'(i));
  end

  assign curEnabled = |(mask & curSel);
  assign ackTake    = (state == REQ) && curEnabled && intAck;
  assign ackClr     = ackTake ? curSel : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      syncQ   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      sync1   <= irqIn;
      sync2   <= sync1;
      syncQ   <= sync2;
      // a fresh edge beats any clear in the same cycle
      pending <= (pending & ~(w1cClr | ackClr)) | rise;
      if (wrMask) mask <= dataBusIn[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      curIdx   <= '0;
      svcIdx   <= '0;
      svcValid <= 1'b0;
      intReq   <= 1'b0;
      intVec   <= '0;
    end else begin
      case (state)
        IDLE: if (winValid) begin
          state  <= REQ;
          curIdx <= winIdx;
          intReq <= 1'b1;
          intVec <= BITS'(VEC_BASE) + BITS'({winIdx, 2'b00});
        end
        REQ: if (!curEnabled) begin
          state  <= IDLE;
          intReq <= 1'b0;
        end else if (intAck) begin
          state    <= SERVICE;
          intReq   <= 1'b0;
          svcIdx   <= curIdx;
          svcValid <= 1'b1;
        end
        SERVICE: if (eoi) begin
          state    <= IDLE;
          svcValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IRQ_ACK_COUNT_EN
  localparam logic [BITS-1:0] ADDR_CNT = BITS'(BASE + 32'd12);
  logic [15:0] ackCnt;
  logic        wrCnt, rdCnt;

  assign wrCnt = we && (memAddr == ADDR_CNT);
  assign rdCnt = re && !we && (memAddr == ADDR_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       ackCnt <= '0;
    else if (wrCnt)   ackCnt <= '0;
    else if (ackTake) ackCnt <= ackCnt + 16'd1;
  end
`endif

  always_comb begin
    dataBusOut = '0;
    if (rdPend) dataBusOut[NUM_SRC-1:0] = pending;
    if (rdMask) dataBusOut[NUM_SRC-1:0] = mask;
    if (rdServ) begin
      dataBusOut[31]  = svcValid;
      dataBusOut[3:0] = svcIdx;
    end
`ifdef IRQ_ACK_COUNT_EN
    if (rdCnt) dataBusOut[15:0] = ackCnt;
`endif
  end

endmodule
